// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle: producer side (master) and subtractor side (slave).
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit subtractor cells: a half subtractor and a full subtractor built from two of them.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b;
    assign bout = ~a & b;

endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.a(a),  .b(b),   .diff(d1),   .bout(b1));
    half_subtractor u_hs1 (.a(d1), .b(bin), .diff(diff), .bout(b2));

    // The two stage borrows are never both set, so OR equals the sum.
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial a - b - bin: one full-subtractor cell, a borrow flop and a bit counter.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic             cell_diff;
    logic             cell_bout;

    full_subtractor u_cell (
        .a   (ra_q[0]),
        .b   (rb_q[0]),
        .bin (br_q),
        .diff(cell_diff),
        .bout(cell_bout)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    br_d    = bus.bin;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                rd_d  = {cell_diff, rd_q[WIDTH-1:1]};
                br_d  = cell_borrow_next();
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Results move to the output registers only here, so they stay put while shifting.
                    diff_d  = {cell_diff, rd_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic cell_borrow_next();
        return cell_bout;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, backpressure, reset abort, random stream.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain integer arithmetic, unsigned and signed views.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        res_t r;
        int   ua, ub, sa, sb, sres;
        ua     = int'(a);
        ub     = int'(b);
        sa     = a[W-1] ? ua - (1 << W) : ua;
        sb     = b[W-1] ? ub - (1 << W) : ub;
        sres   = sa - sb - int'(bin);
        r.diff = W'(ua - ub - int'(bin));
        r.bout = (ua < ub + int'(bin));
        r.ovf  = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
        return r;
    endfunction

    // Launch one operation with out_ready high and check latency and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin);
        res_t exp;
        int   lat;
        exp = model(a, b, bin);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_diff"}, 32'(bus.diff), 32'(exp.diff));
        check({tag, "_bout"}, 32'(bus.bout), 32'(exp.bout));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp.ovf));
        @(negedge clk);
        check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        res_t         exp;
        res_t         q[$];
        logic [W-1:0] held_diff;
        logic         held_bout;
        logic         held_ovf;
        int           sent;
        int           recv;
        int           cyc;
        logic         need_new;

        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;

        run_op("op_5a_3c", 8'h5A, 8'h3C, 1'b0);
        run_op("op_3c_5a", 8'h3C, 8'h5A, 1'b0);
        run_op("op_80_01", 8'h80, 8'h01, 1'b0);
        run_op("op_00_00_b", 8'h00, 8'h00, 1'b1);
        run_op("op_80_00_b", 8'h80, 8'h00, 1'b1);

        // Backpressure: hold the result in DONE while new operands wiggle at the input.
        exp = model(8'hC3, 8'h17, 1'b1);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 8'hC3;
        bus.b         = 8'h17;
        bus.bin       = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        held_diff = bus.diff;
        held_bout = bus.bout;
        held_ovf  = bus.ovf;
        check("bp_diff", 32'(held_diff), 32'(exp.diff));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a        = 8'(i * 37);
            bus.b        = 8'(i * 11 + 3);
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_res", {bus.diff, bus.bout, bus.ovf}, {held_diff, held_bout, held_ovf});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_idle", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("bp_stay_idle", 32'(bus.in_ready), 32'd1);

        // Reset pulse in SHIFT cycle 3 aborts the operation asynchronously.
        bus.in_valid = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'h0F;
        bus.bin      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_diff", 32'(bus.diff), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("op_after_abort", 8'h10, 8'h01, 1'b0);

        // Random stream: in_valid held high, random backpressure, queue-based scoreboard.
        sent     = 0;
        recv     = 0;
        cyc      = 0;
        need_new = 1'b1;
        while (recv < 16 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp = q.pop_front();
                    check("rnd_diff", 32'(bus.diff), 32'(exp.diff));
                    check("rnd_bout", 32'(bus.bout), 32'(exp.bout));
                    check("rnd_ovf", 32'(bus.ovf), 32'(exp.ovf));
                end
                recv++;
            end
            if (sent < 16) begin
                if (need_new) begin
                    bus.a    = 8'($urandom);
                    bus.b    = 8'($urandom);
                    bus.bin  = 1'($urandom_range(0, 1));
                    need_new = 1'b0;
                end
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    q.push_back(model(bus.a, bus.b, bus.bin));
                    sent++;
                    need_new = 1'b1;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("rnd_all_sent", 32'(sent), 32'd16);
        check("rnd_all_recv", 32'(recv), 32'd16);
        check("rnd_queue_empty", 32'(q.size()), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("rnd_no_extra", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor computing `a - b - bin` over WIDTH clock cycles with one full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion of the team's full-adder datapath cells. It sits between a producer and a consumer, with valid/ready handshakes on both sides. It trades latency for area in narrow arithmetic paths.

## Interface
- WIDTH, 8: operand and result width in bits; legal range WIDTH >= 2.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands `a`, `b` and `bin` are valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  `diff`, `bout` and `ovf` are valid
- out_ready  in  1  consumer accepts the result
- diff  out  WIDTH  `(a - b - bin) mod 2^WIDTH`
- bout  out  1  final borrow-out: 1 when `a < b + bin` (unsigned)
- ovf  out  1  signed (two's-complement) overflow of `a - b - bin`

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid` is high, on the clock edge:
    - load `a` into shift register `ra` and `b` into `rb`;
    - set borrow flop `br` <= `bin`;
    - latch `a[WIDTH-1]` and `b[WIDTH-1]` for overflow;
    - clear `cnt` and go to SHIFT.
- **SHIFT** (exactly WIDTH cycles)
  - Each cycle: `d = ra[0]^rb[0]^br` and `br_n = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br)`.
  - Shift `ra` and `rb` right by one.
  - Shift the diff register right, inserting `d` at the MSB; `br` <= `br_n`; `cnt` <= `cnt+1`.
  - On the edge where `cnt == WIDTH-1`:
    - go to DONE;
    - `bout` <= `br_n`;
    - `ovf` <= `(a_msb != b_msb) && (d != a_msb)`.
- **DONE**
  - `out_valid` = 1.
  - `diff`, `bout` and `ovf` are held stable until `out_valid && out_ready`, then go to IDLE.
- `in_valid` is ignored outside IDLE. Operands need only be stable in the accepting cycle.
- No overlap: a new operand is accepted no earlier than the cycle after the result handshake.
- `cnt` width is `$clog2(WIDTH)`; no wrap-around is possible within a legal operation.
- `diff`, `bout` and `ovf` keep their last value in IDLE and SHIFT. Only `out_valid` qualifies them.

## Timing
- Reset values:
  - state = IDLE, so `in_ready` = 1;
  - `out_valid` = 0;
  - `diff` = 0, `bout` = 0, `ovf` = 0;
  - `ra`, `rb`, `br`, `cnt` = 0.
- Reset asserted mid-SHIFT or in DONE: the operation is discarded immediately (asynchronous). After release the block is in IDLE.
- Latency: accept edge at cycle T; `out_valid` goes high after edge T+WIDTH.
- Throughput: one operation per WIDTH+2 cycles when `out_ready` is held high.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Shared package `sub_pkg`:
  - state enum `{IDLE, SHIFT, DONE}`;
  - default `WIDTH` constant.
- Sub-module `full_subtractor`: combinational one-bit cell with ports (a, b, bin, diff, bout), built from two `half_subtractor` instances plus an OR of the borrows. It is instantiated once in the SHIFT datapath.
- The top level holds the FSM, the shift registers, the borrow flop and the counter.

## Test plan
- WIDTH=8: `a`=0x5A, `b`=0x3C, `bin`=0, `out_ready`=1 -> `out_valid` exactly 8 cycles after accept; `diff`=0x1E, `bout`=0, `ovf`=0.
- `a`=0x3C, `b`=0x5A, `bin`=0 -> `diff`=0xE2, `bout`=1, `ovf`=0.
- `a`=0x80, `b`=0x01, `bin`=0 -> `diff`=0x7F, `bout`=0, `ovf`=1. Also `a`=0x00, `b`=0x00, `bin`=1 -> `diff`=0xFF, `bout`=1, `ovf`=0.
- Backpressure:
  - hold `out_ready`=0 for 5 cycles in DONE -> outputs stable, `in_ready`=0, a toggling `in_valid` with new operands is not captured;
  - release -> IDLE next cycle.
- Reset pulse at SHIFT cycle 3 -> `out_valid`=0 and `in_ready`=1 immediately. A following op (0x10 - 0x01) gives 0x0F with no residue from the aborted op.
- Back-to-back: 16 random operand sets with `in_valid` held high and random `out_ready` -> every result matches a reference model and no operation is dropped or duplicated.
